// File: rtl/peripheral_bus_pkg.sv
// Shared definitions for the peripheral bus arbiter: FSM encoding, device ID field and error data.
package peripheral_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_RESP
   } bus_state_e;

   localparam int ID_MSB = 23;
   localparam int ID_LSB = 16;
   localparam int ID_WIDTH = ID_MSB - ID_LSB + 1;

   localparam logic [31:0] PERIPHERAL_BUS_ERROR_DATA = 32'hFFFF_FFFF;

   function automatic logic [ID_WIDTH-1:0] device_id(input logic [23:0] address);
      return address[ID_MSB:ID_LSB];
   endfunction

endpackage

// File: rtl/peripheral_bus_timeout.sv
// WAIT-cycle watchdog for the peripheral bus arbiter; only built when PERIPHERAL_BUS_TIMEOUT_EN is defined.
module peripheral_bus_timeout
   import peripheral_bus_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (start) begin
         count_d = '0;
      end else if (enable && (count_q < CNT_W'(TIMEOUT_CYCLES))) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // count_q holds the number of completed WAIT cycles, so this fires on the last permitted one
   assign expired = enable && (count_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/peripheral_bus_arbiter.sv
// Sequences bridge-to-peripheral transactions: decode, strobe, wait on busy, single-cycle response.
// Optional WAIT timeout is enabled with `define PERIPHERAL_BUS_TIMEOUT_EN.
module peripheral_bus_arbiter
   import peripheral_bus_pkg::*;
#(
   parameter int DEVICE_COUNT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      peripheralBus_we,
   input  logic                      peripheralBus_oe,
   input  logic [23:0]               peripheralBus_address,
   input  logic [3:0]                peripheralBus_byteSelect,
   input  logic [31:0]               peripheralBus_dataWrite,
   output logic                      peripheralBus_busy,
   output logic                      peripheralBus_done,
   output logic                      peripheralBus_error,
   output logic [31:0]               peripheralBus_dataRead,
   output logic [DEVICE_COUNT-1:0]   device_we,
   output logic [DEVICE_COUNT-1:0]   device_oe,
   output logic [23:0]               device_address,
   output logic [3:0]                device_byteSelect,
   output logic [31:0]               device_dataWrite,
   input  logic [DEVICE_COUNT-1:0]   device_busy,
   input  logic [32*DEVICE_COUNT-1:0] device_dataRead
);

   bus_state_e              state_q, state_d;
   logic [23:0]             addr_q, addr_d;
   logic [3:0]              bsel_q, bsel_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    is_write_q, is_write_d;
   logic [DEVICE_COUNT-1:0] sel_q, sel_d;
   logic [DEVICE_COUNT-1:0] we_q, we_d;
   logic [DEVICE_COUNT-1:0] oe_q, oe_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    error_q, error_d;
   logic [31:0]             rdata_q, rdata_d;

   logic                    req;
   logic                    req_ok;
   logic [ID_WIDTH-1:0]     req_id;
   logic [DEVICE_COUNT-1:0] req_sel;
   logic                    sel_busy;
   logic [31:0]             sel_rdata;
   logic                    timer_start;
   logic                    timer_enable;
   logic                    timeout_hit;

   assign req    = peripheralBus_we | peripheralBus_oe;
   assign req_id = device_id(peripheralBus_address);
   assign req_ok = (32'(req_id) < 32'(DEVICE_COUNT)) && (peripheralBus_we ^ peripheralBus_oe);

   // An unmapped ID decodes to an all-zero select, so no strobe can reach any device
   always_comb begin
      req_sel   = '0;
      sel_rdata = '0;
      for (int k = 0; k < DEVICE_COUNT; k++) begin
         req_sel[k] = (32'(req_id) == 32'(k));
         sel_rdata  = sel_rdata | (device_dataRead[32*k +: 32] & {32{sel_q[k]}});
      end
   end

   assign sel_busy     = |(device_busy & sel_q);
   assign timer_start  = (state_q == ST_IDLE) && req && req_ok;
   assign timer_enable = (state_q == ST_WAIT);

`ifdef PERIPHERAL_BUS_TIMEOUT_EN
   peripheral_bus_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .start   (timer_start),
      .enable  (timer_enable),
      .expired (timeout_hit)
   );
`else
   logic [31:0] timeout_unused;
   assign timeout_unused = 32'(TIMEOUT_CYCLES) ^ {31'b0, timer_start ^ timer_enable};
   assign timeout_hit    = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      bsel_d     = bsel_q;
      wdata_d    = wdata_q;
      is_write_d = is_write_q;
      sel_d      = sel_q;
      we_d       = '0;
      oe_d       = '0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      error_d    = 1'b0;
      rdata_d    = '0;

      unique case (state_q)
         ST_IDLE: begin
            if (req) begin
               addr_d     = peripheralBus_address;
               bsel_d     = peripheralBus_byteSelect;
               wdata_d    = peripheralBus_dataWrite;
               is_write_d = peripheralBus_we;
               busy_d     = 1'b1;
               if (req_ok) begin
                  sel_d   = req_sel;
                  we_d    = peripheralBus_we ? req_sel : '0;
                  oe_d    = peripheralBus_oe ? req_sel : '0;
                  state_d = ST_ISSUE;
               end else begin
                  sel_d   = '0;
                  done_d  = 1'b1;
                  error_d = 1'b1;
                  rdata_d = PERIPHERAL_BUS_ERROR_DATA;
                  state_d = ST_RESP;
               end
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
         end
         // Device completion takes priority over a timeout landing on the same cycle
         ST_WAIT: begin
            if (!sel_busy) begin
               done_d  = 1'b1;
               rdata_d = is_write_q ? 32'h0 : sel_rdata;
               state_d = ST_RESP;
            end else if (timeout_hit) begin
               done_d  = 1'b1;
               error_d = 1'b1;
               rdata_d = PERIPHERAL_BUS_ERROR_DATA;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         addr_q     <= '0;
         bsel_q     <= '0;
         wdata_q    <= '0;
         is_write_q <= 1'b0;
         sel_q      <= '0;
         we_q       <= '0;
         oe_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         rdata_q    <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         bsel_q     <= bsel_d;
         wdata_q    <= wdata_d;
         is_write_q <= is_write_d;
         sel_q      <= sel_d;
         we_q       <= we_d;
         oe_q       <= oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         rdata_q    <= rdata_d;
      end
   end

   assign peripheralBus_busy     = busy_q;
   assign peripheralBus_done     = done_q;
   assign peripheralBus_error    = error_q;
   assign peripheralBus_dataRead = rdata_q;
   assign device_we              = we_q;
   assign device_oe              = oe_q;
   assign device_address         = addr_q;
   assign device_byteSelect      = bsel_q;
   assign device_dataWrite       = wdata_q;

endmodule
